// File: rtl/ps2_key_event_ctrl.sv
// ps2_key_event_ctrl: PS/2 scan-code parser for the 10 game keys, with a
// held-key bitmap and a show-ahead event FIFO drained by valid/ready.
// Optional build macro: PS2_TYPEMATIC_EN (repeat makes of held keys are queued).
module ps2_key_event_ctrl #(
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 1200000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     key_pressed,
  input  logic [7:0]               key_data,
  input  logic                     event_ready,
  input  logic                     clear_overflow,
  output logic                     event_valid,
  output logic [3:0]               event_code,
  output logic                     event_make,
  output logic [9:0]               key_held,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  // state   | meaning
  // IDLE    | waiting for the first byte of a sequence
  // EXT     | E0 seen, extended make pending
  // BRK     | F0 seen, non-extended break pending
  // EXT_BRK | E0 and F0 seen, extended break pending
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_EXT     = 2'd1;
  localparam logic [1:0] S_BRK     = 2'd2;
  localparam logic [1:0] S_EXT_BRK = 2'd3;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]       state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [9:0]       held_q, held_d;
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [4:0]       mem_q [DEPTH];
  logic [4:0]       mem_d [DEPTH];

  logic       is_ext, is_brk, final_byte, map_hit;
  logic [3:0] map_idx;
  logic       push, pop, full, push_ok;

  // Decode the current byte against the key map for the current prefix state
  always_comb begin
    is_ext     = (state_q == S_EXT) || (state_q == S_EXT_BRK);
    is_brk     = (state_q == S_BRK) || (state_q == S_EXT_BRK);
    final_byte = key_pressed && (key_data != 8'hE0) && (key_data != 8'hF0);
    map_hit    = 1'b1;
    map_idx    = 4'd0;
    if (is_ext) begin
      case (key_data)
        8'h75:   map_idx = 4'd0;
        8'h6B:   map_idx = 4'd1;
        8'h72:   map_idx = 4'd2;
        8'h74:   map_idx = 4'd3;
        default: map_hit = 1'b0;
      endcase
    end else begin
      case (key_data)
        8'h5A:   map_idx = 4'd4;
        8'h2D:   map_idx = 4'd5;
        8'h16:   map_idx = 4'd6;
        8'h1E:   map_idx = 4'd7;
        8'h26:   map_idx = 4'd8;
        8'h25:   map_idx = 4'd9;
        default: map_hit = 1'b0;
      endcase
    end
  end

  // Parser state and idle-timeout counter; a strobe always takes priority
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    if (key_pressed) begin
      tmo_d = '0;
      case (key_data)
        8'hE0:   state_d = is_brk ? S_EXT_BRK : S_EXT;
        8'hF0:   state_d = is_ext ? S_EXT_BRK : S_BRK;
        default: state_d = S_IDLE;
      endcase
    end else if (state_q == S_IDLE) begin
      tmo_d = '0;
    end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
      state_d = S_IDLE;
      tmo_d   = '0;
    end else begin
      tmo_d = tmo_q + TMO_W'(1);
    end
  end

  // Held-key bitmap update and event push request
  always_comb begin
    held_d = held_q;
    push   = 1'b0;
    if (final_byte && map_hit) begin
      if (!is_brk) begin
        if (!held_q[map_idx]) begin
          held_d[map_idx] = 1'b1;
          push            = 1'b1;
        end else begin
`ifdef PS2_TYPEMATIC_EN
          push = 1'b1;
`else
          push = 1'b0;
`endif
        end
      end else if (held_q[map_idx]) begin
        held_d[map_idx] = 1'b0;
        push            = 1'b1;
      end
    end
  end

  // FIFO bookkeeping; a pop frees the slot a same-cycle push needs when full
  always_comb begin
    pop     = (count_q != '0) && event_ready;
    full    = (count_q == CNT_W'(DEPTH));
    push_ok = push && (!full || pop);
    wr_d    = push_ok ? wr_q + PTR_W'(1) : wr_q;
    rd_d    = pop ? rd_q + PTR_W'(1) : rd_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    mem_d = mem_q;
    if (push_ok) mem_d[wr_q] = {map_idx, !is_brk};
    if (push && full && !pop) ovf_d = 1'b1;
    else if (clear_overflow)  ovf_d = 1'b0;
    else                      ovf_d = ovf_q;
  end

  // State registers, all cleared asynchronously
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      tmo_q   <= '0;
      held_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      held_q  <= held_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      mem_q   <= mem_d;
    end
  end

  // Show-ahead outputs, forced to zero while empty
  always_comb begin
    event_valid = (count_q != '0);
    event_code  = event_valid ? mem_q[rd_q][4:1] : 4'd0;
    event_make  = event_valid ? mem_q[rd_q][0] : 1'b0;
    key_held    = held_q;
    fifo_count  = count_q;
    overflow    = ovf_q;
  end

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
module tb_ps2_key_event_ctrl;

  localparam int DEPTH = 8;
  localparam int TMO   = 40;

  logic       clock = 1'b0;
  logic       reset;
  logic       key_pressed;
  logic [7:0] key_data;
  logic       event_ready;
  logic       clear_overflow;
  logic       event_valid;
  logic [3:0] event_code;
  logic       event_make;
  logic [9:0] key_held;
  logic [3:0] fifo_count;
  logic       overflow;

  int total = 0;
  int bad   = 0;
  logic [4:0] sb [$];
  logic [7:0] key_byte [10] = '{8'h75, 8'h6B, 8'h72, 8'h74, 8'h5A,
                                8'h2D, 8'h16, 8'h1E, 8'h26, 8'h25};

  ps2_key_event_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset), .key_pressed(key_pressed), .key_data(key_data),
    .event_ready(event_ready), .clear_overflow(clear_overflow),
    .event_valid(event_valid), .event_code(event_code), .event_make(event_make),
    .key_held(key_held), .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    key_pressed = 1'b1;
    key_data    = b;
    @(negedge clock);
    key_pressed = 1'b0;
    key_data    = 8'h00;
  endtask

  task automatic press_key(input int idx, input bit brk);
    if (idx < 4) send_byte(8'hE0);
    if (brk) send_byte(8'hF0);
    send_byte(key_byte[idx]);
  endtask

  task automatic exp_push(input int code, input bit make);
    sb.push_back({code[3:0], make});
  endtask

  task automatic drain(input string tag);
    logic [4:0] e;
    for (int n = 0; n < 40 && event_valid; n++) begin
      if (sb.size() == 0) begin
        check({tag, "_extra_event"}, {31'd0, event_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check({tag, "_code"}, {28'd0, event_code}, {28'd0, e[4:1]});
        check({tag, "_make"}, {31'd0, event_make}, {31'd0, e[0]});
      end
      event_ready = 1'b1;
      @(negedge clock);
      event_ready = 1'b0;
    end
    check({tag, "_missing_events"}, sb.size(), 32'd0);
    check({tag, "_empty"}, {31'd0, event_valid}, 32'd0);
    sb.delete();
  endtask

  initial begin
    reset = 1'b1; key_pressed = 1'b0; key_data = 8'h00;
    event_ready = 1'b0; clear_overflow = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_valid", {31'd0, event_valid}, 32'd0);
    check("rst_held", {22'd0, key_held}, 32'd0);
    check("rst_count", {28'd0, fifo_count}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    reset = 1'b0;

    // Extended make, latency and show-ahead
    press_key(0, 0); exp_push(0, 1);
    check("up_valid", {31'd0, event_valid}, 32'd1);
    check("up_code", {28'd0, event_code}, 32'd0);
    check("up_make", {31'd0, event_make}, 32'd1);
    check("up_held", {22'd0, key_held}, 32'h001);
    check("up_count", {28'd0, fifo_count}, 32'd1);
    drain("up");

    // Extended make/break of Right, then release Up
    press_key(3, 0); exp_push(3, 1);
    check("right_held", {22'd0, key_held}, 32'h009);
    drain("right_mk");
    press_key(3, 1); exp_push(3, 0);
    check("right_brk_held", {22'd0, key_held}, 32'h001);
    drain("right_brk");
    press_key(0, 1); exp_push(0, 0);
    drain("up_brk");
    check("up_brk_held", {22'd0, key_held}, 32'h000);

    // Typematic repeats of "1"
    send_byte(8'h16); send_byte(8'h16); send_byte(8'h16);
    send_byte(8'hF0); send_byte(8'h16);
    exp_push(6, 1);
`ifdef PS2_TYPEMATIC_EN
    exp_push(6, 1); exp_push(6, 1);
`endif
    exp_push(6, 0);
    check("rep_count", {28'd0, fifo_count}, sb.size());
    drain("rep");
    check("rep_held", {22'd0, key_held}, 32'h000);

    // Overflow: 20 events into 8 entries
    for (int i = 0; i < 10; i++) begin
      press_key(i, 0);
      if (i < DEPTH) exp_push(i, 1);
    end
    for (int i = 0; i < 10; i++) press_key(i, 1);
    check("ovf_count", {28'd0, fifo_count}, 32'd8);
    check("ovf_set", {31'd0, overflow}, 32'd1);
    check("ovf_held", {22'd0, key_held}, 32'h000);
    @(negedge clock); clear_overflow = 1'b1;
    @(negedge clock); clear_overflow = 1'b0;
    check("ovf_clear", {31'd0, overflow}, 32'd0);
    check("ovf_count_kept", {28'd0, fifo_count}, 32'd8);
    drain("ovf");

    // Timeout aborts the pending extended prefix
    send_byte(8'hE0);
    repeat (TMO + 2) @(negedge clock);
    send_byte(8'h75);
    check("tmo_no_event", {31'd0, event_valid}, 32'd0);
    check("tmo_held", {22'd0, key_held}, 32'h000);
    send_byte(8'h5A); exp_push(4, 1);
    check("tmo_idle_held", {22'd0, key_held}, 32'h010);
    drain("tmo_enter");
    send_byte(8'hE0);
    repeat (TMO - 3) @(negedge clock);
    send_byte(8'h75); exp_push(0, 1);
    check("tmo_window_held", {22'd0, key_held}, 32'h011);
    drain("tmo_window");
    press_key(4, 1); exp_push(4, 0);
    press_key(0, 1); exp_push(0, 0);
    drain("tmo_release");
    check("tmo_release_held", {22'd0, key_held}, 32'h000);

    // Push and pop on the same edge while full
    for (int i = 2; i < 10; i++) begin
      press_key(i, 0); exp_push(i, 1);
    end
    check("full_count", {28'd0, fifo_count}, 32'd8);
    send_byte(8'hE0);
    begin
      logic [4:0] e;
      e = sb.pop_front();
      check("full_head_code", {28'd0, event_code}, {28'd0, e[4:1]});
      check("full_head_make", {31'd0, event_make}, {31'd0, e[0]});
    end
    event_ready = 1'b1; key_pressed = 1'b1; key_data = 8'h75;
    exp_push(0, 1);
    @(negedge clock);
    event_ready = 1'b0; key_pressed = 1'b0; key_data = 8'h00;
    check("pp_count", {28'd0, fifo_count}, 32'd8);
    check("pp_ovf", {31'd0, overflow}, 32'd0);
    check("pp_held", {22'd0, key_held}, 32'h3FD);
    drain("pp");

    // Asynchronous reset mid-sequence
    send_byte(8'hE0); send_byte(8'hF0);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", {31'd0, event_valid}, 32'd0);
    check("arst_held", {22'd0, key_held}, 32'h000);
    check("arst_count", {28'd0, fifo_count}, 32'd0);
    check("arst_code", {27'd0, event_code, event_make}, 32'd0);
    check("arst_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clock); reset = 1'b0;
    sb.delete();
    send_byte(8'h6B);
    check("post_rst_valid", {31'd0, event_valid}, 32'd0);
    check("post_rst_held", {22'd0, key_held}, 32'h000);
    send_byte(8'h2D); exp_push(5, 1);
    check("post_rst_r_held", {22'd0, key_held}, 32'h020);
    drain("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
